// File: rtl/bcd_pkg.sv
// Shared constants and types for the digit-serial BCD adder controller.
package bcd_pkg;

    localparam int DW       = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } state_e;

    function automatic logic is_bcd(input logic [DW-1:0] d);
        return d <= DW'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder slice: decimal sum, decimal carry and invalid-digit flag.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DW-1:0] da,
    input  logic [DW-1:0] db,
    input  logic          ci,
    output logic [DW-1:0] s,
    output logic          co,
    output logic          inv
);

    logic [DW:0] sum;

    // NOTE: every output gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        sum = {1'b0, da} + {1'b0, db} + (DW+1)'(ci);
        s   = sum[DW-1:0];
        co  = 1'b0;
        inv = !is_bcd(da) || !is_bcd(db);
        if (sum > (DW+1)'(BCD_MAX)) begin
            s  = sum[DW-1:0] + DW'(BCD_CORR);
            co = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: sequences one bcd_digit_add slice over DIGITS digits,
// least-significant first, with start/busy/done handshake and invalid-digit abort.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CW     = 3
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 start,
    input  logic [4*DIGITS-1:0]  a,
    input  logic [4*DIGITS-1:0]  b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*DIGITS-1:0]  result,
    output logic                 cout,
    output logic                 error
);

    localparam int              W    = DW * DIGITS;
    localparam logic [CW-1:0]   LAST = CW'(DIGITS - 1);

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic [W-1:0]   opa_q;
    logic [W-1:0]   opb_q;
    logic [W-1:0]   result_q;
    logic           cout_q;
    logic           error_q;
    logic           done_q;
    logic           busy_q;

    logic [DW-1:0]  digit_s;
    logic           digit_co;
    logic           digit_inv;

    logic [W-1:0]   result_d;
    logic [W-1:0]   opa_d;
    logic [W-1:0]   opb_d;

    bcd_digit_add u_digit (
        .da  (opa_q[DW-1:0]),
        .db  (opb_q[DW-1:0]),
        .ci  (carry_q),
        .s   (digit_s),
        .co  (digit_co),
        .inv (digit_inv)
    );

    // New digits enter the result at the top; after DIGITS shifts digit 0 sits in the low nibble.
    generate
        if (DIGITS == 1) begin : g_one_digit
            assign result_d = digit_s;
            assign opa_d    = '0;
            assign opb_d    = '0;
        end else begin : g_multi_digit
            assign result_d = {digit_s, result_q[W-1:DW]};
            assign opa_d    = {{DW{1'b0}}, opa_q[W-1:DW]};
            assign opb_d    = {{DW{1'b0}}, opb_q[W-1:DW]};
        end
    endgenerate

    // NOTE: all sequential state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            // NOTE: the operand shift registers are plain flops here and are cleared like everything else.
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end

                ADD: begin
                    if (digit_inv) begin
                        error_q  <= 1'b1;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= FIN;
                    end else begin
                        result_q <= result_d;
                        opa_q    <= opa_d;
                        opb_q    <= opb_d;
                        carry_q  <= digit_co;
                        if (cnt_q == LAST) begin
                            cout_q  <= digit_co;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end

                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign error  = error_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench: DIGITS=2 and DIGITS=4 instances, scoreboard of expected results.
module tb_bcd_serial_add_ctrl;

    logic Clock = 1'b0;
    logic Resetn;
    always #5 Clock = ~Clock;

    logic        d2_start, d2_cin, d2_busy, d2_done, d2_cout, d2_error;
    logic [7:0]  d2_a, d2_b, d2_result;
    logic        d4_start, d4_cin, d4_busy, d4_done, d4_cout, d4_error;
    logic [15:0] d4_a, d4_b, d4_result;

    bcd_serial_add_ctrl #(.DIGITS(2), .CW(2)) dut2 (
        .Clock(Clock), .Resetn(Resetn), .start(d2_start), .a(d2_a), .b(d2_b), .cin(d2_cin),
        .busy(d2_busy), .done(d2_done), .result(d2_result), .cout(d2_cout), .error(d2_error)
    );

    bcd_serial_add_ctrl #(.DIGITS(4), .CW(3)) dut4 (
        .Clock(Clock), .Resetn(Resetn), .start(d4_start), .a(d4_a), .b(d4_b), .cin(d4_cin),
        .busy(d4_busy), .done(d4_done), .result(d4_result), .cout(d4_cout), .error(d4_error)
    );

    typedef struct {
        logic [15:0] result;
        logic        cout;
        logic        error;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   sel   = 1'b0;

    wire        o_busy   = sel ? d4_busy  : d2_busy;
    wire        o_done   = sel ? d4_done  : d2_done;
    wire        o_cout   = sel ? d4_cout  : d2_cout;
    wire        o_error  = sel ? d4_error : d2_error;
    wire [15:0] o_result = sel ? d4_result : {8'h00, d2_result};

    // Decimal reference: mod-10 arithmetic on integer digits.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic cv, input int nd);
        exp_t e;
        int   c, s, da, db;
        e.result = 16'h0; e.cout = 1'b0; e.error = 1'b0; e.lat = nd + 1;
        c = int'(cv);
        for (int k = 0; k < nd; k++) begin
            da = int'((av >> (4*k)) & 16'hF);
            db = int'((bv >> (4*k)) & 16'hF);
            if (da > 9 || db > 9) begin
                e.result = 16'h0; e.cout = 1'b0; e.error = 1'b1; e.lat = k + 2;
                return e;
            end
            s = da + db + c;
            c = (s >= 10) ? 1 : 0;
            s = s % 10;
            e.result = e.result | (16'(s) << (4*k));
        end
        e.cout = (c == 1);
        return e;
    endfunction

    task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
        if (sel) begin
            d4_a = av; d4_b = bv; d4_cin = cv; d4_start = sv;
        end else begin
            d2_a = av[7:0]; d2_b = bv[7:0]; d2_cin = cv; d2_start = sv;
        end
    endtask

    // Runs one operation; optionally re-pulses start at cycle restart_k after acceptance.
    task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input int restart_k);
        exp_t e, got;
        bit   seen;
        e = model(av, bv, cv, sel ? 4 : 2);
        got = e;
        seen = 1'b0;
        @(negedge Clock);
        drive(av, bv, cv, 1'b1);
        sb.push_back(e);
        @(posedge Clock);
        for (int k = 1; k <= e.lat + 3; k++) begin
            @(negedge Clock);
            drive(16'($urandom), 16'($urandom), 1'($urandom), (k == restart_k));
            #1;
            if (o_busy !== (k <= e.lat)) begin
                $display("FAIL %s busy cyc %0d: got %b want %b", name, k, o_busy, (k <= e.lat));
                fails++;
            end
            tests++;
            if (o_done !== (k == e.lat)) begin
                $display("FAIL %s done cyc %0d: got %b want %b", name, k, o_done, (k == e.lat));
                fails++;
            end
            tests++;
            if (o_done === 1'b1) begin
                if (sb.size() == 0) begin
                    $display("FAIL %s unexpected done cyc %0d: got done with empty scoreboard", name, k);
                    fails++;
                end else begin
                    got = sb.pop_front();
                    seen = 1'b1;
                end
                tests++;
            end
            if (seen) begin
                if ({o_result, o_cout, o_error} !== {got.result, got.cout, got.error}) begin
                    $display("FAIL %s result cyc %0d: got %h/c%b/e%b want %h/c%b/e%b", name, k,
                             o_result, o_cout, o_error, got.result, got.cout, got.error);
                    fails++;
                end
                tests++;
            end
        end
        if (sb.size() != 0) begin
            $display("FAIL %s pending: got %0d outstanding results want 0", name, sb.size());
            fails++;
            sb.delete();
        end
        tests++;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        d2_start = 1'b0; d2_a = 8'h0;  d2_b = 8'h0;  d2_cin = 1'b0;
        d4_start = 1'b0; d4_a = 16'h0; d4_b = 16'h0; d4_cin = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            if ({o_busy, o_done, o_cout, o_error} !== 4'b0000) begin
                $display("FAIL reset_flags dut%0d: got %b want 0000", s, {o_busy, o_done, o_cout, o_error});
                fails++;
            end
            tests++;
            if (o_result !== 16'h0) begin
                $display("FAIL reset_result dut%0d: got %h want 0000", s, o_result);
                fails++;
            end
            tests++;
        end
        sel = 1'b0;
        Resetn = 1'b1;
    endtask

    task automatic test_basic();
        run_op("add45_38", 16'h0045, 16'h0038, 1'b0, 0);
        run_op("add27_19c", 16'h0027, 16'h0019, 1'b1, 0);
    endtask

    task automatic test_max();
        run_op("max99_99c", 16'h0099, 16'h0099, 1'b1, 0);
        run_op("add50_50", 16'h0050, 16'h0050, 1'b0, 0);
    endtask

    task automatic test_invalid();
        run_op("inv3A_01", 16'h003A, 16'h0001, 1'b0, 0);
        run_op("add12_34", 16'h0012, 16'h0034, 1'b0, 0);
        run_op("invA1_11", 16'h00A1, 16'h0011, 1'b0, 0);
        run_op("inv11_1F", 16'h0011, 16'h001F, 1'b1, 0);
    endtask

    task automatic test_start_while_busy();
        run_op("busy_add", 16'h0045, 16'h0038, 1'b0, 1);
        run_op("busy_fin", 16'h0045, 16'h0038, 1'b0, 3);
    endtask

    // start held for 10 edges: accepts at t, t+4, t+8; operands changed just before each re-accept.
    task automatic test_back_to_back();
        exp_t e;
        int   ndone;
        ndone = 0;
        @(negedge Clock);
        drive(16'h0045, 16'h0038, 1'b0, 1'b1);
        sb.push_back(model(16'h0045, 16'h0038, 1'b0, 2));
        @(posedge Clock);
        for (int k = 1; k <= 14; k++) begin
            @(negedge Clock);
            if (k == 4) begin
                drive(16'h0027, 16'h0019, 1'b1, 1'b1);
                sb.push_back(model(16'h0027, 16'h0019, 1'b1, 2));
            end else if (k == 8) begin
                drive(16'h0091, 16'h0010, 1'b0, 1'b1);
                sb.push_back(model(16'h0091, 16'h0010, 1'b0, 2));
            end else if (k == 10) begin
                drive(16'h0, 16'h0, 1'b0, 1'b0);
            end
            #1;
            if (o_done !== (k == 3 || k == 7 || k == 11)) begin
                $display("FAIL b2b done cyc %0d: got %b want %b", k, o_done, (k == 3 || k == 7 || k == 11));
                fails++;
            end
            tests++;
            if (o_done === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                ndone++;
                if ({o_result, o_cout, o_error} !== {e.result, e.cout, e.error}) begin
                    $display("FAIL b2b result cyc %0d: got %h/c%b/e%b want %h/c%b/e%b", k,
                             o_result, o_cout, o_error, e.result, e.cout, e.error);
                    fails++;
                end
                tests++;
            end
        end
        if (ndone != 3 || sb.size() != 0) begin
            $display("FAIL b2b count: got %0d dones, %0d pending want 3 dones, 0 pending", ndone, sb.size());
            fails++;
            sb.delete();
        end
        tests++;
    endtask

    task automatic test_reset_mid();
        @(negedge Clock);
        drive(16'h0045, 16'h0038, 1'b0, 1'b1);
        @(posedge Clock);
        @(negedge Clock);
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        #1;
        if ({o_busy, o_done, o_cout, o_error} !== 4'b0000 || o_result !== 16'h0) begin
            $display("FAIL reset_mid state: got busy%b done%b c%b e%b r%h want all 0",
                     o_busy, o_done, o_cout, o_error, o_result);
            fails++;
        end
        tests++;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                $display("FAIL reset_mid quiet cyc %0d: got done%b busy%b want 0 0", k, o_done, o_busy);
                fails++;
            end
            tests++;
        end
        run_op("after_reset07_05", 16'h0007, 16'h0005, 1'b0, 0);
    endtask

    task automatic test_digits4();
        sel = 1'b1;
        run_op("d4_9999_0001", 16'h9999, 16'h0001, 1'b0, 0);
        run_op("d4_1234_8766", 16'h1234, 16'h8766, 1'b0, 0);
        run_op("d4_2468_1357", 16'h2468, 16'h1357, 1'b0, 0);
        run_op("d4_inv_dig2", 16'h0B00, 16'h1111, 1'b0, 0);
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_invalid();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_digits4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
